// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32 core:
// ALU opcodes, major opcodes, FSM states and mux encodings.
package riscv_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b10000;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_MUL  = 5'b01000;
  localparam logic [4:0] ALU_SLLI = 5'b00001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R,
    S_EXEC_I, S_WB_ALU, S_MEM_ADDR, S_MEM_ACC,
    S_WB_MEM, S_BRANCH, S_JAL, S_ILLEGAL
  } state_e;

  typedef enum logic { CLS_R, CLS_I } op_class_e;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_sel;
    logic       pc_we;
    logic       ir_we;
    logic       tgt_we;
    logic       reg_we;
    logic       pc_src;
    logic [1:0] wb_sel;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       illegal;
  } ctl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Maps {class, funct3, funct7} of R/I ALU instructions
// to the 5-bit ALU opcode and a legality flag.
module alu_op_decode
  import riscv_pkg::*;
(
  input  op_class_e  cls,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [4:0] alu_op,
  output logic       legal
);

  logic [4:0] r_op;
  assign r_op = {funct7[5], funct7[0], funct3};

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    if (cls == CLS_R) begin
      alu_op = r_op;
      // the funct7 filter rejects bits outside [5] and [0]
      legal  = (funct7 inside {7'h00, 7'h20, 7'h01}) &&
               (r_op inside {ALU_ADD, ALU_SUB, ALU_AND,
                             ALU_OR, ALU_MUL, ALU_SLLI});
    end else begin
      unique case (funct3)
        3'b000: begin alu_op = ALU_ADD; legal = 1'b1; end
        3'b110: begin alu_op = ALU_OR;  legal = 1'b1; end
        3'b111: begin alu_op = ALU_AND; legal = 1'b1; end
        3'b001: begin
          if (funct7 == 7'b0000000) begin
            alu_op = ALU_SLLI;
            legal  = 1'b1;
          end
        end
        default: begin end
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM: sequences fetch, decode, execute,
// memory and writeback over the shared datapath.
module mc_control
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [4:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_sel,
  output logic        pc_we,
  output logic        ir_we,
  output logic        tgt_we,
  output logic        reg_we,
  output logic        pc_src,
  output logic [1:0]  wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        illegal
);

  state_e     state, nxt;
  ctl_t       c;
  op_class_e  cls;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] dec_op;
  logic       dec_legal;
  logic       is_store;
  logic       taken;
  logic       unused_regs;

  assign opc         = instr[6:0];
  assign f3          = instr[14:12];
  assign f7          = instr[31:25];
  assign unused_regs = ^{instr[24:15], instr[11:7]};
  assign is_store    = (opc == OP_STORE);
  assign taken       = (f3 == 3'b000) ? zero : !zero;
  assign cls         = (state == S_EXEC_I) ? CLS_I : CLS_R;

  alu_op_decode u_dec (
    .cls    (cls),
    .funct3 (f3),
    .funct7 (f7),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    c   = '0;
    nxt = state;
    unique case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          c.ir_we = 1'b1;
          c.pc_we = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.tgt_we    = 1'b1;
        c.imm_sel   = (opc == OP_JAL) ? IMM_J : IMM_B;
        unique case (opc)
          OP_R:              nxt = S_EXEC_R;
          OP_I:              nxt = S_EXEC_I;
          OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
          OP_BRANCH:         nxt = S_BRANCH;
          OP_JAL:            nxt = S_JAL;
          default:           nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = dec_op;
        nxt = dec_legal ? S_WB_ALU : S_ILLEGAL;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.imm_sel   = IMM_I;
        c.alu_op    = dec_op;
        nxt = dec_legal ? S_WB_ALU : S_ILLEGAL;
      end
      S_WB_ALU: begin
        c.reg_we = 1'b1;
        c.wb_sel = WB_ALUOUT;
        nxt      = S_FETCH;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.imm_sel   = is_store ? IMM_S : IMM_I;
        nxt = (f3 == 3'b010) ? S_MEM_ACC : S_ILLEGAL;
      end
      S_MEM_ACC: begin
        c.mem_req  = 1'b1;
        c.addr_sel = 1'b1;
        c.mem_we   = is_store;
        if (mem_ready) nxt = is_store ? S_FETCH : S_WB_MEM;
      end
      S_WB_MEM: begin
        c.reg_we = 1'b1;
        c.wb_sel = WB_MDR;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_SUB;
        if (f3[2:1] != 2'b00) begin
          nxt = S_ILLEGAL;
        end else begin
          nxt      = S_FETCH;
          c.pc_we  = taken;
          c.pc_src = taken;
        end
      end
      S_JAL: begin
        c.reg_we = 1'b1;
        c.wb_sel = WB_PC;
        c.pc_we  = 1'b1;
        c.pc_src = 1'b1;
        nxt      = S_FETCH;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default:   nxt = S_IDLE;
    endcase
  end

  // reset silences every enable immediately, even mid-request
  assign {alu_op, alu_src_a, alu_src_b, imm_sel,
          pc_we, ir_we, tgt_we, reg_we, pc_src,
          wb_sel, mem_req, mem_we, addr_sel,
          illegal} = reset ? '0 : c;

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the lab RISC-V core: the producer side of the ALU's 5-bit opcode interface. A state machine reads the instruction register and sequences the shared datapath: fetch, decode, execute, memory access and writeback. For every execute-phase ALU use, it drives the ALU opcode as {funct7[5], funct7[0], funct3}.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- instr  in  32  instruction register contents (valid from DECODE onward)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- alu_op  out  5  ADD 00000, SUB 10000, AND 00111, OR 00110, MUL 01000, SLLI 00001
- alu_src_a  out  2  00 PC, 01 OLDPC, 10 RS1
- alu_src_b  out  2  00 RS2, 01 IMM, 10 const 4
- imm_sel  out  2  00 I, 01 S, 10 B, 11 J
- pc_we, ir_we, tgt_we, reg_we  out  1 each  register write enables
- pc_src  out  1  0 ALU result, 1 branch-target register
- wb_sel  out  2  00 ALUOUT, 01 MDR, 10 PC
- mem_req, mem_we  out  1 each  memory request / write qualifier
- addr_sel  out  1  0 PC, 1 ALUOUT
- illegal  out  1  sticky illegal-instruction flag

## Operation
- Any output not named in a state below is 0. alu_op defaults to ADD.
- **IDLE:** the reset state. All outputs are 0. Next state is FETCH.
- **FETCH:** drive mem_req=1, addr_sel=PC, src_a=PC, src_b=4, alu_op=ADD.
  - Hold while mem_ready=0.
  - On mem_ready=1, pulse ir_we and pc_we (pc_src=0), then go to DECODE.
- **DECODE:** src_a=OLDPC, src_b=IMM, alu_op=ADD, tgt_we=1. imm_sel is J for jal and B otherwise. Dispatch on instr[6:0]:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → ILLEGAL
- **EXEC_R:** src_a=RS1, src_b=RS2, alu_op={f7[5],f7[0],f3}.
  - Legal encodings: add, sub, and, or, mul (f7=0000001, f3=000), sll. Others → ILLEGAL.
  - Next state is WB_ALU.
- **EXEC_I:** src_a=RS1, src_b=IMM, imm_sel=I.
  - addi → ADD, ori → OR, andi → AND.
  - slli → SLLI, only when f7=0000000.
  - Others → ILLEGAL. Next state is WB_ALU.
- **WB_ALU:** reg_we=1, wb_sel=ALUOUT. Next state is FETCH.
- **MEM_ADDR:** src_a=RS1, src_b=IMM, ADD. imm_sel is S for stores and I for loads. f3 must be 010, else ILLEGAL. Next state is MEM_ACC.
- **MEM_ACC:** mem_req=1, addr_sel=ALUOUT, mem_we=1 for stores.
  - Hold while mem_ready=0.
  - On mem_ready=1, loads go to WB_MEM and stores go to FETCH.
- **WB_MEM:** reg_we=1, wb_sel=MDR. Next state is FETCH.
- **BRANCH:** src_a=RS1, src_b=RS2, alu_op=SUB.
  - beq (f3=000) is taken when zero=1; bne (f3=001) is taken when zero=0.
  - If taken, pc_we=1 with pc_src=1.
  - Other f3 → ILLEGAL. Next state is FETCH.
- **JAL:** reg_we=1, wb_sel=PC (already PC+4), pc_we=1, pc_src=1. Next state is FETCH.
- **ILLEGAL:** illegal=1, all enables 0. Stays in ILLEGAL until reset.

## Timing
- The state register resets asynchronously to IDLE, and illegal clears to 0.
- Reset asserted mid-operation (including mid-request) drops mem_req and all enables combinationally in the same cycle.
- Outputs are decoded combinationally from the state register and instr.
- ir_we and pc_we in FETCH, and the MEM_ACC exit, depend on mem_ready in the same cycle (Mealy).
- mem_req and addr_sel stay stable while waiting for mem_ready.
- mem_ready outside FETCH and MEM_ACC is ignored.
- Cycle counts with zero-wait memory: R/I-type 4, lw 5, sw 4, branch 3, jal 3.
  - Each memory wait cycle adds one cycle.
  - Post-reset first fetch request appears 1 cycle after reset deassertion.
- Writes to x0 are suppressed by the register file, not by this block.

## Structure
- Shared package riscv_pkg holds:
  - ALU opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL, ALU_SLLI)
  - RV32 major opcode constants
  - the state enum
  - encodings for src_a, src_b, wb_sel and imm_sel
- One sub-module, alu_op_decode: combinational {opcode class, funct3, funct7} → {alu_op, legal}, shared by EXEC_R and EXEC_I.

## Test plan
- **add:** reset, then add x3,x1,x2 (0x002081B3) with mem_ready=1 → states IDLE, FETCH, DECODE, EXEC_R, WB_ALU.
  - EXEC_R: alu_op=00000.
  - WB_ALU: reg_we=1, wb_sel=00.
  - Back in FETCH on cycle 5.
- **sub/mul:** sub 0x402081B3 → EXEC_R alu_op=10000; mul 0x022081B3 → EXEC_R alu_op=01000.
- **lw with wait states:** lw with mem_ready low for 3 cycles in MEM_ACC → mem_req=1, addr_sel=1 held for 4 cycles; then WB_MEM with wb_sel=01, reg_we=1.
- **branches:**
  - beq with zero=1 → BRANCH pc_we=1, pc_src=1.
  - beq with zero=0 → pc_we=0.
  - bne inverts both cases.
- **illegal:** opcode 0x0000007F → ILLEGAL; illegal=1 holds for 10 cycles with mem_req=0; reset returns to IDLE with illegal=0.
- **reset mid-fetch:** assert reset during FETCH with mem_ready=0 → mem_req=0 immediately; after release, IDLE then FETCH.
